// File: rtl/vga_text_fetch.sv
// vga_text_fetch: 80x30 text-mode display controller.
// Generates 640x480@60 timing from the pixel clock, fetches character codes
// from the VRAM display port, looks them up in an 8x16 font ROM and
// serialises the glyph bits into a 1-bit pixel stream. Sync, blank and
// frameStart are delayed so that they stay aligned with the pixel stream.
//
// Ports:
//   clk           pixel clock, rising edge
//   nRst          asynchronous active-low reset
//   displayAddr   VRAM read address (registered)
//   displayRdData VRAM read data, one clock after displayAddr
//   fontAddr      font ROM address {charCode, glyphRow} (registered)
//   fontData      font ROM data, one clock after fontAddr, bit 7 leftmost
//   pixel         video bit, 1 = foreground
//   hsync/vsync   active-low syncs
//   blank         1 outside the visible area
//   frameStart    one-clock pulse with the first pixel of each frame
module vga_text_fetch #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned COLS      = 80,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        nRst,
  output logic [12:0] displayAddr,
  input  logic [7:0]  displayRdData,
  output logic [11:0] fontAddr,
  input  logic [7:0]  fontData,
  output logic        pixel,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frameStart
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  logic              h_wrap_c;
  logic              frame_wrap_c;
  logic              active_c;
  logic              hs_on_c;
  logic              vs_on_c;
  logic              fs_c;
  logic [ADDR_W-1:0] cell_addr_c;

  // Pipeline taps: index 0 is one clock after the counters, index 3 is four.
  logic [ADDR_W-1:0] disp_addr_q;
  logic [11:0]       font_addr_q;
  logic [1:0][3:0]   vrow_q;
  logic [3:0][2:0]   hpix_q;
  logic [3:0]        act_q;
  logic [3:0]        hs_on_q;
  logic [3:0]        vs_on_q;
  logic [3:0]        fs_q;

  logic              pixel_q;
  logic              hsync_q;
  logic              vsync_q;
  logic              blank_q;
  logic              frame_start_q;

  // Counter / row-base next state and raw timing decode for the current (h,v).
  always_comb begin
    h_cnt_d    = h_cnt_q + CNT_W'(1);
    v_cnt_d    = v_cnt_q;
    row_base_d = row_base_q;

    h_wrap_c     = (h_cnt_q == CNT_W'(H_TOTAL - 1));
    frame_wrap_c = h_wrap_c && (v_cnt_q == CNT_W'(V_TOTAL - 1));

    if (h_wrap_c) begin
      h_cnt_d = '0;
      if (frame_wrap_c) begin
        v_cnt_d    = '0;
        row_base_d = ADDR_W'(BASE_ADDR);
      end else begin
        v_cnt_d = v_cnt_q + CNT_W'(1);
        // Leaving the last glyph row of a visible text row: next text row.
        if ((v_cnt_q[3:0] == 4'hF) && (v_cnt_q < CNT_W'(V_ACTIVE))) begin
          row_base_d = row_base_q + ADDR_W'(COLS);
        end
      end
    end

    active_c    = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    hs_on_c     = (h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END));
    vs_on_c     = (v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END));
    fs_c        = (h_cnt_q == '0) && (v_cnt_q == '0);
    cell_addr_c = row_base_q + ADDR_W'(h_cnt_q[CNT_W-1:3]);
  end

  // Counters, fetch pipeline and aligned outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      row_base_q    <= ADDR_W'(BASE_ADDR);
      disp_addr_q   <= ADDR_W'(BASE_ADDR);
      font_addr_q   <= '0;
      vrow_q        <= '0;
      hpix_q        <= '0;
      act_q         <= '0;
      hs_on_q       <= '0;
      vs_on_q       <= '0;
      fs_q          <= '0;
      pixel_q       <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_base_q <= row_base_d;

      // Stage 1: character address; stage 3: glyph address from VRAM data.
      disp_addr_q <= cell_addr_c;
      vrow_q      <= {vrow_q[0], v_cnt_q[3:0]};
      font_addr_q <= {displayRdData, vrow_q[1]};

      hpix_q  <= {hpix_q[2:0], h_cnt_q[2:0]};
      act_q   <= {act_q[2:0], active_c};
      hs_on_q <= {hs_on_q[2:0], hs_on_c};
      vs_on_q <= {vs_on_q[2:0], vs_on_c};
      fs_q    <= {fs_q[2:0], fs_c};

      // Stage 5: pick the glyph bit, MSB is the leftmost pixel of the cell.
      pixel_q       <= act_q[3] & fontData[3'd7 - hpix_q[3]];
      hsync_q       <= ~hs_on_q[3];
      vsync_q       <= ~vs_on_q[3];
      blank_q       <= ~act_q[3];
      frame_start_q <= fs_q[3];
    end
  end

  assign displayAddr = disp_addr_q;
  assign fontAddr    = font_addr_q;
  assign pixel       = pixel_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frameStart  = frame_start_q;

endmodule

// File: doc/vga_text_fetch.md
Name: vga_text_fetch

Overview:
- Display-side controller for the 80x30 text mode. Generates 640x480@60 VGA timing from a single pixel-rate clock.
- Fetches character codes from the display port of the video RAM and looks each code up in an external 8x16 font ROM.
- Serialises the resulting font bits into a 1-bit pixel stream. Sync and blank outputs are delayed to stay aligned with that stream.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- COLS, 80, character cells per text row
- BASE_ADDR, 0, VRAM address of the top-left character

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- nRst  in  1  asynchronous active-low reset
- displayAddr  out  13  VRAM display-side read address
- displayRdData  in  8  VRAM read data, valid one clock after displayAddr
- fontAddr  out  12  font ROM address {charCode[7:0], glyphRow[3:0]}
- fontData  in  8  font ROM data, valid one clock after fontAddr, bit 7 = leftmost pixel
- pixel  out  1  video bit, 1 = foreground
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  1 outside the visible area
- frameStart  out  1  one-clock pulse aligned with the first pixel of each frame

Behaviour:
- Reset values: all counters 0, pipeline registers 0, displayAddr=BASE_ADDR, fontAddr=0, pixel=0, hsync=1, vsync=1, blank=1, frameStart=0.
- Counters:
  - hCount runs 0..H_TOTAL-1 (H_TOTAL = sum of the four H_* parameters = 800).
  - vCount increments when hCount wraps; range 0..V_TOTAL-1 (525).
  - Both wrap to 0 together at the end of the frame.
- Raw timing, per counter position (h,v):
  - active = h<H_ACTIVE and v<V_ACTIVE.
  - hsyncRaw is low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsyncRaw is low for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Row base address:
  - rowBase holds BASE_ADDR for text row 0.
  - On the hCount wrap out of a line where v[3:0]==15 and v<V_ACTIVE, rowBase <= rowBase+COLS.
  - On the frame wrap, rowBase <= BASE_ADDR.
  - Arithmetic is 13-bit modulo 8192 (addresses wrap).
- Pipeline, for counter value (h,v) present in cycle t:
  - Edge t+1: displayAddr <= rowBase + h[9:3], 13-bit wrap; updated every clock, including during blanking.
  - Edge t+3: fontAddr <= {displayRdData, v[3:0] delayed 2}.
  - Edge t+5: pixel <= active_d4 ? fontData[7 - h[2:0]_d4] : 0.
  - Total latency from counters to pixel is 5 clocks.
  - hsync, vsync, blank (= !active) and frameStart (= h==0 and v==0) pass through the same 5-stage delay. They change on the same edge as the corresponding pixel.
- No handshake: VRAM and font ROM are fixed one-cycle-latency reads. Host-side VRAM accesses do not stall this block.
- Reset mid-frame: all outputs go to reset values immediately (asynchronous). After release, timing restarts at (0,0) and the first frameStart appears 5 clocks after the first active edge.
- The top-left pixel occupies the first clock of each frame; no other clock is skipped or duplicated.

Test Plan:
- Reset, then hold nRst=0 for 10 clocks -> pixel=0, hsync=1, vsync=1, blank=1, displayAddr=0 throughout.
- Free-run one frame -> hsync low exactly 96 clocks per 800-clock line; vsync low exactly 1600 clocks (2 lines) per 420000-clock frame; blank low 640 clocks per visible line; frameStart pulses once per 420000 clocks.
- Model VRAM with addr 0=0x41 and font (0x41, row 0)=0xA5 -> first 8 pixels after frameStart read 1,0,1,0,0,1,0,1; line 0 displayAddr sequence 0 (x8), 1 (x8), …, 79.
- Observe line 16 -> displayAddr starts at 80, fontAddr low nibble 0; line 479 -> base 29*80=2320, glyph row 15.
- Set BASE_ADDR=8150 -> text row 1 base wraps to (8150+80) mod 8192 = 38.
- Assert nRst at h=300, v=200 for 3 clocks -> outputs take reset values immediately; after release, the next frameStart comes 5 clocks after the first active edge and the line period is 800 clocks.
